wb_stage_regfile: RTL and testbench

- Write-back stage plus the integer register file for the 5-stage RV64I pipeline; consumes the outputs of the MEM/WB pipeline register.
- Selects the write-back value (ALU result, load data, or PC+4) and commits it to the 32x64 register file.
- Provides two combinational read ports to decode, with write-through bypass.
- Exports the write-back bus for forwarding, a retired-instruction counter, and a sticky select-error flag.

---
 rtl/wb_stage_regfile.sv | 112 +++++++++++
 tb/tb_wb_stage_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_regfile.sv
// Write-back stage and integer register file for the RV64I pipeline.
// Selects the write-back value, commits it, and serves two bypassed read ports.
module wb_stage_regfile #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  localparam int unsigned IdxW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [IdxW-1:0] rd_idx_in,
  input  logic            reg_write_in,
  input  logic [1:0]      mem_to_reg_in,
  input  logic            valid_in,
  input  logic [IdxW-1:0] rs1_idx,
  input  logic [IdxW-1:0] rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic [IdxW-1:0] wb_rd,
  output logic            wb_we,
  output logic [63:0]     instret,
  output logic            sel_err
);

  localparam logic [1:0] SelAlu = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;
  localparam logic [1:0] SelPc4 = 2'b10;
  localparam logic [1:0] SelBad = 2'b11;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [63:0]     instret_q, instret_d;
  logic            sel_err_q, sel_err_d;
  logic            sel_bad;

  // Write-back select; the illegal encoding yields zero.
  always_comb begin
    wb_data = '0;
    unique case (mem_to_reg_in)
      SelAlu:  wb_data = alu_result_in;
      SelMem:  wb_data = mem_data_in;
      SelPc4:  wb_data = pc_plus4_in;
      SelBad:  wb_data = '0;
      default: wb_data = '0;
    endcase
  end

  assign sel_bad = (mem_to_reg_in == SelBad);
  assign wb_rd   = rd_idx_in;
  assign wb_we   = valid_in & reg_write_in & (rd_idx_in != '0) & ~sel_bad & ~reset;

  // Read ports with same-cycle write-through; wb_we already excludes x0 and reset.
  always_comb begin
    rs1_data = '0;
    if (rs1_idx != '0) begin
      if (wb_we && (wb_rd == rs1_idx)) begin
        rs1_data = wb_data;
      end else begin
        rs1_data = regs_q[rs1_idx];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_idx != '0) begin
      if (wb_we && (wb_rd == rs2_idx)) begin
        rs2_data = wb_data;
      end else begin
        rs2_data = regs_q[rs2_idx];
      end
    end
  end

  // Every real slot retires, including stores, branches and illegal selects.
  always_comb begin
    instret_d = instret_q;
    sel_err_d = sel_err_q;
    if (valid_in) begin
      instret_d = instret_q + 64'd1;
      if (sel_bad) begin
        sel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      instret_q <= instret_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[rd_idx_in] <= wb_data;
    end
  end

  assign instret = instret_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile: vector table plus hand-written
// sequences for reset, sticky error and counter wrap.
module tb_wb_stage_regfile;

  logic        clk;
  logic        reset;
  logic [63:0] alu_result_in, mem_data_in, pc_plus4_in;
  logic [4:0]  rd_idx_in, rs1_idx, rs2_idx;
  logic        reg_write_in, valid_in;
  logic [1:0]  mem_to_reg_in;
  logic [63:0] rs1_data, rs2_data, wb_data, instret;
  logic [4:0]  wb_rd;
  logic        wb_we, sel_err;

  int checks = 0;
  int errors = 0;

  wb_stage_regfile #(.XLEN(64), .NREGS(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_result_in (alu_result_in),
    .mem_data_in   (mem_data_in),
    .pc_plus4_in   (pc_plus4_in),
    .rd_idx_in     (rd_idx_in),
    .reg_write_in  (reg_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .valid_in      (valid_in),
    .rs1_idx       (rs1_idx),
    .rs2_idx       (rs2_idx),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .instret       (instret),
    .sel_err       (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] e_rs1;
    logic [63:0] e_rs2;
    logic [63:0] e_wb;
    logic        e_we;
    logic [63:0] e_instret;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] mem, input logic [63:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2);
    valid_in = v; reg_write_in = rw; mem_to_reg_in = sel; rd_idx_in = rd;
    alu_result_in = alu; mem_data_in = mem; pc_plus4_in = pc;
    rs1_idx = r1; rs2_idx = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 64'd0, 64'd0, r1, r2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // valid rw sel rd alu mem pc rs1 rs2 | e_rs1 e_rs2 e_wb e_we e_instret e_err
    vecs[0]  = '{1, 1, 2'b00, 5'd5, 64'h1234, 0, 0, 5'd5, 5'd0,
                 64'h1234, 64'h0, 64'h1234, 1, 64'd0, 0};
    vecs[1]  = '{0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd5, 5'd5,
                 64'h1234, 64'h1234, 64'h0, 0, 64'd1, 0};
    vecs[2]  = '{1, 1, 2'b01, 5'd7, 64'h1, 64'hDEAD_BEEF, 64'h2, 5'd7, 5'd5,
                 64'hDEAD_BEEF, 64'h1234, 64'hDEAD_BEEF, 1, 64'd1, 0};
    vecs[3]  = '{1, 1, 2'b10, 5'd8, 64'h1, 64'h2, 64'h8000_0004, 5'd8, 5'd7,
                 64'h8000_0004, 64'hDEAD_BEEF, 64'h8000_0004, 1, 64'd2, 0};
    vecs[4]  = '{1, 1, 2'b00, 5'd0, 64'hFF, 0, 0, 5'd0, 5'd0,
                 64'h0, 64'h0, 64'hFF, 0, 64'd3, 0};
    vecs[5]  = '{0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd7, 5'd8,
                 64'hDEAD_BEEF, 64'h8000_0004, 64'h0, 0, 64'd4, 0};
    vecs[6]  = '{0, 1, 2'b00, 5'd9, 64'h55, 0, 0, 5'd9, 5'd0,
                 64'h0, 64'h0, 64'h55, 0, 64'd4, 0};
    vecs[7]  = '{1, 0, 2'b00, 5'd9, 64'h77, 0, 0, 5'd9, 5'd5,
                 64'h0, 64'h1234, 64'h77, 0, 64'd4, 0};
    vecs[8]  = '{0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd9, 5'd5,
                 64'h0, 64'h1234, 64'h0, 0, 64'd5, 0};
    vecs[9]  = '{1, 1, 2'b11, 5'd10, 64'h99, 64'h88, 64'h66, 5'd10, 5'd10,
                 64'h0, 64'h0, 64'h0, 0, 64'd5, 0};
    vecs[10] = '{0, 0, 2'b11, 5'd10, 64'h99, 0, 0, 5'd10, 5'd9,
                 64'h0, 64'h0, 64'h0, 0, 64'd6, 1};
    vecs[11] = '{1, 1, 2'b00, 5'd5, 64'h5555, 0, 0, 5'd5, 5'd5,
                 64'h5555, 64'h5555, 64'h5555, 1, 64'd6, 1};
    vecs[12] = '{0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd5, 5'd0,
                 64'h5555, 64'h0, 64'h0, 0, 64'd7, 1};
    vecs[13] = '{1, 1, 2'b00, 5'd6, 64'hA, 0, 0, 5'd6, 5'd0,
                 64'hA, 64'h0, 64'hA, 1, 64'd7, 1};
    vecs[14] = '{1, 1, 2'b00, 5'd6, 64'hB, 0, 0, 5'd6, 5'd6,
                 64'hB, 64'hB, 64'hB, 1, 64'd8, 1};
    vecs[15] = '{0, 0, 2'b00, 5'd0, 0, 0, 0, 5'd6, 5'd10,
                 64'hB, 64'h0, 64'h0, 0, 64'd9, 1};

    // Reset, then every index on both ports reads zero while reset is held.
    reset = 1'b1;
    idle(5'd0, 5'd0);
    step();
    step();
    drive(1'b1, 1'b1, 2'b00, 5'd3, 64'h77, 0, 0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_idx = 5'(i);
      rs2_idx = 5'(31 - i);
      #1;
      check($sformatf("reset_rs1_x%0d", i), rs1_data, 64'd0);
      check($sformatf("reset_rs2_x%0d", 31 - i), rs2_data, 64'd0);
    end
    check("reset_wb_we", {63'd0, wb_we}, 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_sel_err", {63'd0, sel_err}, 64'd0);
    check("reset_wb_data", wb_data, 64'h77);
    check("reset_wb_rd", {59'd0, wb_rd}, 64'd3);
    step();
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].sel, vecs[i].rd, vecs[i].alu, vecs[i].mem,
            vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);
      check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e_rs1);
      check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e_rs2);
      check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wb);
      check($sformatf("v%0d_wb_rd", i), {59'd0, wb_rd}, {59'd0, vecs[i].rd});
      check($sformatf("v%0d_wb_we", i), {63'd0, wb_we}, {63'd0, vecs[i].e_we});
      check($sformatf("v%0d_instret", i), instret, vecs[i].e_instret);
      check($sformatf("v%0d_sel_err", i), {63'd0, sel_err}, {63'd0, vecs[i].e_err});
      step();
    end

    // Sticky error survives ten legal writes to x11..x20.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 2'b00, 5'(11 + i), 64'(100 + i), 0, 0, 5'd0, 5'd0);
      @(negedge clk);
      check($sformatf("sticky_err_%0d", i), {63'd0, sel_err}, 64'd1);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      idle(5'(11 + i), 5'd10);
      #1;
      check($sformatf("readback_x%0d", 11 + i), rs1_data, 64'(100 + i));
    end
    check("instret_after_loop", instret, 64'd19);

    // Writes, then reset colliding with a write to x3.
    drive(1'b1, 1'b1, 2'b00, 5'd3, 64'hAA, 0, 0, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b1, 2'b00, 5'd4, 64'hBB, 0, 0, 5'd3, 5'd0);
    #1;
    check("pre_reset_x3", rs1_data, 64'hAA);
    step();
    reset = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 5'd3, 64'hCC, 0, 0, 5'd3, 5'd4);
    @(negedge clk);
    check("reset_write_we", {63'd0, wb_we}, 64'd0);
    step();
    reset = 1'b0;
    idle(5'd3, 5'd4);
    #1;
    check("post_reset_x3", rs1_data, 64'd0);
    check("post_reset_x4", rs2_data, 64'd0);
    check("post_reset_instret", instret, 64'd0);
    check("post_reset_sel_err", {63'd0, sel_err}, 64'd0);
    drive(1'b1, 1'b1, 2'b00, 5'd3, 64'h11, 0, 0, 5'd3, 5'd0);
    #1;
    check("first_write_bypass_x3", rs1_data, 64'h11);
    step();
    idle(5'd3, 5'd0);
    #1;
    check("first_write_x3", rs1_data, 64'h11);
    check("first_write_instret", instret, 64'd1);

    // Counter wrap from all-ones.
    drive(1'b1, 1'b0, 2'b00, 5'd0, 0, 0, 0, 5'd0, 5'd0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    @(negedge clk);
    check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("wrap_zero", instret, 64'd0);
    step();
    check("wrap_one", instret, 64'd1);
    idle(5'd0, 5'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
